// File: rtl/capture_pkg.sv
// capture_pkg: definitions shared by the frame capture writer.
//   - LANES         : pixels packed per 32-bit memory word
//   - ST_* / state_t: capture FSM states
//   - be_from_lanes : byteenable mask for a word holding n valid lanes
package capture_pkg;

    localparam int unsigned LANES = 4;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_CAPTURE  = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        WAIT_SOF = ST_WAIT_SOF,
        CAPTURE  = ST_CAPTURE,
        DONE     = ST_DONE
    } state_t;

    // Lanes 0..n-1 enabled; n outside 1..4 yields no lanes.
    function automatic logic [3:0] be_from_lanes(input logic [2:0] n);
        case (n)
            3'd1:    return 4'h1;
            3'd2:    return 4'h3;
            3'd3:    return 4'h7;
            3'd4:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/frame_capture_writer_if.sv
// frame_capture_writer_if: single-port on-chip RAM slave bus.
//   mem_address    word address
//   mem_byteenable byte lanes written
//   mem_chipselect select, tracks mem_write
//   mem_write      one-cycle write strobe
//   mem_writedata  32-bit write data
//   mem_clken      RAM clock enable
// master: the capture writer; slave: the RAM.
interface frame_capture_writer_if #(
    parameter int unsigned ADDR_W = 15
);
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [31:0]       mem_writedata;
    logic              mem_clken;

    modport master (
        output mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );

    modport slave (
        input  mem_address, mem_byteenable, mem_chipselect,
               mem_write, mem_writedata, mem_clken
    );
endinterface

// File: rtl/pixel_word_packer.sv
// pixel_word_packer: packs 8-bit pixels little-endian into 32-bit words.
//   clk, reset_n : clock, async active-low reset
//   discard      : drop any partial word (abort)
//   accept       : pixel is taken this cycle
//   first        : accepted pixel starts a fresh word in lane 0 (sof)
//   last         : accepted pixel ends the frame; flush partial word
//   pixel        : pixel value
//   word_emit    : a word completes this cycle (combinational)
//   word_data    : completed word, unused upper lanes zero
//   word_be      : byteenable for the completed word
module pixel_word_packer
    import capture_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        discard,
    input  logic        accept,
    input  logic        first,
    input  logic        last,
    input  logic [7:0]  pixel,
    output logic        word_emit,
    output logic [31:0] word_data,
    output logic [3:0]  word_be
);
    localparam int unsigned LANE_W = $clog2(LANES);

    logic [LANE_W-1:0] lane_q;
    logic [31:0]       data_q;
    logic [LANE_W-1:0] lane_eff;

    // A sof pixel restarts packing, so the incoming lane and the partial
    // word are both taken as empty before inserting the pixel.
    always_comb begin
        lane_eff  = first ? '0 : lane_q;
        word_data = first ? '0 : data_q;
        word_data[{lane_eff, 3'b000} +: 8] = pixel;
        word_emit = accept && (last || (lane_eff == LANE_W'(LANES - 1)));
        word_be   = be_from_lanes(3'(lane_eff) + 3'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            data_q <= '0;
        end else if (discard) begin
            lane_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            if (word_emit) begin
                lane_q <= '0;
                data_q <= '0;
            end else begin
                lane_q <= lane_eff + LANE_W'(1);
                data_q <= word_data;
            end
        end
    end

endmodule

// File: rtl/frame_capture_writer.sv
// frame_capture_writer: captures one grayscale frame into on-chip RAM.
//   clk, reset_n      : clock, async active-low reset
//   arm               : start/restart a capture (samples base_addr, max_words)
//   base_addr         : first word address
//   max_words         : word budget; a write beyond it raises overflow
//   pix_valid/data    : pixel stream, no backpressure
//   pix_sof/pix_eof   : frame markers, qualified by pix_valid
//   mem               : RAM slave bus (master side)
//   busy/done/overflow: capture status
//   words_written     : words committed in this capture
module frame_capture_writer
    import capture_pkg::*;
#(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DEPTH  = 32000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               arm,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [15:0]        max_words,
    input  logic               pix_valid,
    input  logic [7:0]         pix_data,
    input  logic               pix_sof,
    input  logic               pix_eof,
    frame_capture_writer_if.master mem,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [15:0]        words_written
);
    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [15:0]       max_q;
    logic [ADDR_W-1:0] wr_addr;   // address of the next write
    logic [15:0]       wr_count;  // writes issued, including one in flight
    logic              fin_pend;  // eof write in flight; done follows it

    logic [ADDR_W-1:0] mem_address_q;
    logic [3:0]        mem_be_q;
    logic              mem_write_q;
    logic [31:0]       mem_data_q;
    logic              mem_clken_q;

    logic              accept;
    logic              resync;
    logic [ADDR_W-1:0] addr_eff;
    logic [ADDR_W-1:0] addr_next;
    logic [15:0]       cnt_eff;
    logic              word_emit;
    logic [31:0]       word_data;
    logic [3:0]        word_be;

    // arm takes priority: a pixel in the arm cycle is never accepted.
    always_comb begin
        accept    = pix_valid && !arm &&
                    (((state == WAIT_SOF) && pix_sof) || (state == CAPTURE));
        resync    = accept && pix_sof;
        addr_eff  = resync ? base_q : wr_addr;
        cnt_eff   = resync ? '0 : wr_count;
        addr_next = (addr_eff == ADDR_W'(DEPTH - 1)) ? '0 : addr_eff + ADDR_W'(1);
    end

    pixel_word_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .discard   (arm),
        .accept    (accept),
        .first     (pix_sof),
        .last      (pix_eof),
        .pixel     (pix_data),
        .word_emit (word_emit),
        .word_data (word_data),
        .word_be   (word_be)
    );

    // words_written trails wr_count by a cycle so the reported count moves
    // after the write strobe, while wr_count already covers the in-flight
    // write for the next address and the budget check.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            base_q        <= '0;
            max_q         <= '0;
            wr_addr       <= '0;
            wr_count      <= '0;
            fin_pend      <= 1'b0;
            mem_address_q <= '0;
            mem_be_q      <= '0;
            mem_write_q   <= 1'b0;
            mem_data_q    <= '0;
            mem_clken_q   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            words_written <= '0;
        end else begin
            mem_clken_q   <= 1'b1;
            mem_write_q   <= 1'b0;
            words_written <= wr_count;
            if (fin_pend) begin
                fin_pend <= 1'b0;
                done     <= 1'b1;
                busy     <= 1'b0;
            end
            if (arm) begin
                state         <= WAIT_SOF;
                base_q        <= base_addr;
                max_q         <= max_words;
                wr_addr       <= base_addr;
                wr_count      <= '0;
                words_written <= '0;
                fin_pend      <= 1'b0;
                busy          <= 1'b1;
                done          <= 1'b0;
                overflow      <= 1'b0;
            end else if (accept) begin
                state <= CAPTURE;
                if (resync) begin
                    wr_addr       <= base_q;
                    wr_count      <= '0;
                    words_written <= '0;
                end
                if (word_emit) begin
                    if (cnt_eff == max_q) begin
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end else begin
                        mem_write_q   <= 1'b1;
                        mem_address_q <= addr_eff;
                        mem_data_q    <= word_data;
                        mem_be_q      <= word_be;
                        wr_addr       <= addr_next;
                        wr_count      <= cnt_eff + 16'd1;
                        if (pix_eof) begin
                            state    <= DONE;
                            fin_pend <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign mem.mem_address    = mem_address_q;
    assign mem.mem_byteenable = mem_be_q;
    assign mem.mem_chipselect = mem_write_q;
    assign mem.mem_write      = mem_write_q;
    assign mem.mem_writedata  = mem_data_q;
    assign mem.mem_clken      = mem_clken_q;

endmodule

// File: tb/tb_frame_capture_writer.sv
module tb_frame_capture_writer;

    localparam int ADDR_W = 15;
    localparam int DEPTH  = 32000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              arm = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [15:0]       max_words = '0;
    logic              pix_valid = 1'b0;
    logic [7:0]        pix_data = '0;
    logic              pix_sof = 1'b0;
    logic              pix_eof = 1'b0;
    logic              busy, done, overflow;
    logic [15:0]       words_written;

    frame_capture_writer_if #(.ADDR_W(ADDR_W)) mem_if ();

    frame_capture_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .arm           (arm),
        .base_addr     (base_addr),
        .max_words     (max_words),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_sof       (pix_sof),
        .pix_eof       (pix_eof),
        .mem           (mem_if),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame-level view of the capture. Pixels of the current
    // word sit in a queue; a word is written when four are held or eof arrives.
    typedef enum {M_IDLE, M_WAIT, M_CAP, M_DONE} mode_t;
    mode_t           m_mode;
    byte unsigned    pbuf[$];
    int              m_base, m_max, m_words;
    bit              m_fin_pend;

    // Expected DUT outputs for the cycle after the last model step.
    bit              e_write, e_busy, e_done, e_ovf, e_clken;
    logic [31:0]     e_addr, e_data;
    logic [3:0]      e_be;
    logic [15:0]     e_ww;

    task automatic model_reset();
        m_mode = M_IDLE; pbuf.delete();
        m_base = 0; m_max = 0; m_words = 0; m_fin_pend = 0;
        e_write = 0; e_busy = 0; e_done = 0; e_ovf = 0; e_clken = 0;
        e_addr = '0; e_data = '0; e_be = '0; e_ww = '0;
    endtask

    task automatic model_step(input bit a, input bit v, input byte unsigned d,
                              input bit s, input bit e);
        bit fin_now = m_fin_pend;
        e_clken = 1;
        e_write = 0;
        m_fin_pend = 0;
        if (fin_now) begin e_done = 1; e_busy = 0; end
        if (a) begin
            m_mode = M_WAIT; m_base = int'(base_addr); m_max = int'(max_words);
            m_words = 0; pbuf.delete();
            e_busy = 1; e_done = 0; e_ovf = 0; e_ww = 0;
        end else begin
            bit take = v && ((m_mode == M_WAIT && s) || m_mode == M_CAP);
            bit rs = take && s;
            int prev_words = m_words;
            if (rs) begin pbuf.delete(); m_words = 0; m_mode = M_CAP; end
            if (take) begin
                pbuf.push_back(d);
                if (pbuf.size() == 4 || e) begin
                    if (m_words == m_max) begin
                        e_ovf = 1; e_done = 1; e_busy = 0; m_mode = M_DONE;
                    end else begin
                        logic [31:0] w = '0;
                        for (int i = 0; i < pbuf.size(); i++)
                            w = w | (32'(pbuf[i]) << (8 * i));
                        e_write = 1;
                        e_addr  = 32'((m_base + m_words) % DEPTH);
                        e_data  = w;
                        e_be    = 4'((1 << pbuf.size()) - 1);
                        m_words++;
                        if (e) begin m_mode = M_DONE; m_fin_pend = 1; end
                    end
                    pbuf.delete();
                end
            end
            e_ww = rs ? 16'd0 : 16'(prev_words);
        end
    endtask

    task automatic check_all();
        check("mem_write",      32'(mem_if.mem_write),      32'(e_write));
        check("mem_chipselect", 32'(mem_if.mem_chipselect), 32'(e_write));
        check("mem_address",    32'(mem_if.mem_address),    e_addr);
        check("mem_writedata",  mem_if.mem_writedata,       e_data);
        check("mem_byteenable", 32'(mem_if.mem_byteenable), 32'(e_be));
        check("mem_clken",      32'(mem_if.mem_clken),      32'(e_clken));
        check("busy",           32'(busy),                  32'(e_busy));
        check("done",           32'(done),                  32'(e_done));
        check("overflow",       32'(overflow),              32'(e_ovf));
        check("words_written",  32'(words_written),         32'(e_ww));
    endtask

    // One cycle: check the outputs of the current cycle, drive the next inputs.
    task automatic cyc(input bit a, input bit v, input byte unsigned d, input bit s, input bit e);
        @(negedge clk);
        check_all();
        arm = a; pix_valid = v; pix_data = d; pix_sof = s; pix_eof = e;
        if (reset_n) model_step(a, v, d, s, e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'($urandom), 0, 0);
    endtask

    task automatic arm_cap(input int base, input int maxw);
        base_addr = ADDR_W'(base);
        max_words = 16'(maxw);
        cyc(1, 0, 8'h00, 0, 0);
    endtask

    // n pixels starting at value v0; sof on the first (and at sof_mid),
    // optional eof on the last, idle gaps with probability gap_pct.
    task automatic frame(input int n, input byte unsigned v0, input bit with_eof,
                         input int gap_pct, input int sof_mid);
        for (int i = 0; i < n; i++) begin
            if (int'($urandom_range(99)) < gap_pct) cyc(0, 0, 8'hEE, 0, 0);
            cyc(0, 1, 8'(v0 + 8'(i)), (i == 0) || (i == sof_mid), with_eof && (i == n - 1));
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
        arm = 0; pix_valid = 0; pix_sof = 0; pix_eof = 0;
        model_step(0, 0, 8'h00, 0, 0);
    endtask

    initial begin
        model_reset();
        idle(3);
        release_reset();
        idle(2);

        // 8-pixel frame -> two full words at 0 and 1
        arm_cap(0, 100);
        frame(8, 8'h01, 1, 0, -1);
        idle(3);

        // 6-pixel frame -> second word partial, be 0x3
        arm_cap(0, 100);
        frame(6, 8'h11, 1, 0, -1);
        idle(3);

        // address wrap across DEPTH-1
        arm_cap(31998, 100);
        frame(16, 8'h40, 0, 0, -1);
        idle(2);

        // budget of two words, no eof
        arm_cap(0, 2);
        frame(12, 8'h80, 0, 0, -1);
        idle(3);

        // max_words = 0 overflows on the first word
        arm_cap(7, 0);
        frame(4, 8'h90, 1, 0, -1);
        idle(2);

        // pre-sof pixels, gaps, mid-frame resync
        arm_cap(5, 50);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'hA0 + 8'(i)), 0, i == 4);
        frame(14, 8'hB0, 1, 40, 7);
        idle(3);

        // one-pixel frame; arm colliding with a pixel
        arm_cap(20, 10);
        cyc(0, 1, 8'h5A, 1, 1);
        idle(3);
        base_addr = 15'd30; max_words = 16'd10;
        cyc(1, 1, 8'h77, 1, 0);
        frame(4, 8'hC0, 1, 0, -1);
        idle(2);

        // abort with three lanes filled, then a fresh frame at base
        arm_cap(10, 50);
        frame(7, 8'hD0, 0, 0, -1);
        arm_cap(10, 50);
        idle(2);
        frame(5, 8'hE0, 1, 0, -1);
        idle(3);

        // asynchronous reset mid-capture
        arm_cap(100, 50);
        frame(6, 8'h30, 0, 0, -1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'($urandom), i == 0, 0);
        release_reset();
        idle(2);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bit a = int'($urandom_range(99)) < 2;
            if (a) begin
                base_addr = ($urandom_range(3) == 0) ? ADDR_W'(DEPTH - 1 - int'($urandom_range(3)))
                                                     : ADDR_W'($urandom_range(DEPTH - 1));
                max_words = ($urandom_range(3) == 0) ? 16'($urandom_range(2))
                                                     : 16'($urandom_range(40));
            end
            cyc(a, int'($urandom_range(99)) < 70, 8'($urandom),
                int'($urandom_range(99)) < 4, int'($urandom_range(99)) < 4);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_capture_writer.md
# frame_capture_writer

- Capture stage directly upstream of the Nios II on-chip memory in the D8M camera path.
- Takes an 8-bit grayscale pixel stream with frame markers and packs four pixels per 32-bit word.
- Writes each word into the 32000-word on-chip RAM through its single-port slave signals.
- Software arms one capture at a time and polls busy/done/overflow.

## Interface

Parameters:
- ADDR_W, 15, memory word-address width
- DEPTH, 32000, memory depth in words; addresses wrap from DEPTH-1 to 0

Ports (single clock domain; reset asynchronous, active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- arm  in  1  one-cycle pulse that starts or restarts a capture
- base_addr  in  ADDR_W  first word address, sampled on arm
- max_words  in  16  word budget, sampled on arm
- pix_valid  in  1  pixel strobe; no backpressure
- pix_data  in  8  pixel value
- pix_sof  in  1  first pixel of frame, qualified by pix_valid
- pix_eof  in  1  last pixel of frame, qualified by pix_valid
- mem_address  out  ADDR_W  RAM word address
- mem_byteenable  out  4  RAM byte lanes
- mem_chipselect  out  1  equals mem_write
- mem_write  out  1  one-cycle write strobe
- mem_writedata  out  32  packed pixels
- mem_clken  out  1  constant 1 after reset
- busy  out  1  high in WAIT_SOF and CAPTURE
- done  out  1  sticky; cleared by arm
- overflow  out  1  sticky; cleared by arm
- words_written  out  16  words committed this capture

## Operation

- States: IDLE, WAIT_SOF, CAPTURE, DONE.
- **IDLE**
  - arm: latch base_addr and max_words, clear counters/done/overflow, go to WAIT_SOF.
- **WAIT_SOF**
  - Pixels without pix_sof are ignored.
  - pix_valid&pix_sof: accept that pixel into lane 0, go to CAPTURE.
- **CAPTURE**
  - Each accepted pixel fills the next lane; lane k occupies writedata[8k+7:8k] (little-endian).
  - Fourth lane filled: issue a write with byteenable 4'hF.
  - pix_eof pixel accepted: issue a write with byteenable covering lanes 0..k (4'h1, 4'h3, 4'h7 or 4'hF), then go to DONE.
  - pix_sof while in CAPTURE (resync): discard the partial word, reset the address to the latched base and words_written to 0; the sof pixel becomes lane 0.
- **Address and count**
  - Write address is base + words_written, wrapping modulo DEPTH.
  - words_written increments by one per issued write.
- **Overflow**
  - A write attempted when words_written == max_words is suppressed; overflow=1 and the block goes to DONE.
  - max_words=0 therefore overflows on the first word.
- **DONE**
  - done=1; further pixels are ignored.
  - arm: behaves as arm in IDLE.
- **arm in WAIT_SOF or CAPTURE**
  - Abort: the partial word is discarded without a write; counters are cleared and the block returns to WAIT_SOF.
- **Simultaneous events**
  - arm and pix_valid in the same cycle: arm wins; the pixel is dropped.
  - pix_sof and pix_eof on the same pixel: a one-pixel frame, one write with byteenable 4'h1.

## Timing

- **Reset:** every output is 0 and the state is IDLE; mem_clken rises to 1 on the first clk edge after reset_n deasserts.
- **Write latency:** a word completed by the pixel accepted in cycle t gives mem_write=1 in cycle t+1 for exactly one cycle, with address, data and byteenable valid that cycle. words_written shows the new count from t+2.
- **Throughput:** one pixel per cycle sustained. The RAM never stalls, so there are no write wait states.
- **End of frame:** eof accepted at t gives its write at t+1, done=1 and busy=0 from t+2.
- **Overflow:** overflow and done are both 1 from t+1 (t = cycle the overflowing word completed); no write occurs at t+1.
- **Status outputs:** arm at t gives busy=1 and done=overflow=0 from t+1.
- **Write outputs when idle:** mem_address, mem_writedata and mem_byteenable hold their last values while mem_write=0.

## Structure

- **Shared package** (capture_pkg): state enum, LANES=4 constant, byteenable-from-lane-count function.
- **Sub-module** pixel_word_packer: lane counter, data shift/assembly, flush with partial byteenable, discard input.
- **Top level:** the FSM, the address/word counter with DEPTH wrap, and the status flags.

## Test plan

- Arm with base 0, max 100; 8-pixel frame 0x01..0x08 (sof on first, eof on last) -> writes addr 0 data 0x04030201 be F, addr 1 data 0x08070605 be F; done=1; words_written=2.
- 6-pixel frame 0x11..0x16 -> second write at addr 1, be 0x3, writedata[15:0]=0x1615; done one cycle after that write.
- Base 31998; 16 pixels at one per cycle -> writes at addresses 31998, 31999, 0, 1 on consecutive 4-cycle strides.
- max_words=2; 12 pixels, no eof -> exactly 2 writes, third write absent, overflow=1 and done=1 on the cycle it was due.
- Pixels before sof, pix_valid gaps inside the frame, and a second sof mid-frame -> pre-sof pixels never written, gaps do not change packing, resync restarts at base with words_written=0.
- reset_n low mid-capture -> all outputs 0 immediately (asynchronously), no write on the following edges; arm mid-capture with 3 lanes filled -> no partial write, busy stays 1, next sof frame lands at base.
